// File: rtl/ofifo_pkg.sv
// ---------------------------------------------------------------------------
// ofifo_pkg : shared sizing constants for the output psum FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ofifo_pkg;

  localparam int OFIFO_COL     = 8;
  localparam int OFIFO_BW_PSUM = 22;
  localparam int OFIFO_DEPTH   = 8;
  localparam int OFIFO_PTR_W   = $clog2(OFIFO_DEPTH) + 1;

endpackage

`default_nettype wire

// File: rtl/ofifo_if.sv
// ---------------------------------------------------------------------------
// ofifo_if : psum push/pop bus between MAC array, OFIFO and consumer
// Optional o_overflow present with OFIFO_OVERFLOW_FLAG_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ofifo_if
  import ofifo_pkg::*;
#(
  parameter int col     = OFIFO_COL,
  parameter int bw_psum = OFIFO_BW_PSUM
) ();

  logic [col*bw_psum-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*bw_psum-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic                   o_overflow;
`endif

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready
`ifdef OFIFO_OVERFLOW_FLAG_EN
    , input o_overflow
`endif
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready
`ifdef OFIFO_OVERFLOW_FLAG_EN
    , output o_overflow
`endif
  );

endinterface

`default_nettype wire

// File: rtl/ofifo_col.sv
// ---------------------------------------------------------------------------
// ofifo_col : one column's circular buffer, first-word-fall-through head.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int bw_psum = OFIFO_BW_PSUM,
  parameter int depth   = OFIFO_DEPTH
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               wr,
  input  wire logic               rd,
  input  wire logic [bw_psum-1:0] in,
  output logic      [bw_psum-1:0] out,
  output logic                    empty,
  output logic                    full
);

  localparam int ADDR_W = $clog2(depth);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [bw_psum-1:0] mem_q [depth];
  logic               push;
  logic               pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign out   = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    pop      = rd & ~empty;
    push     = wr & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= in;
  end

endmodule

`default_nettype wire

// File: rtl/ofifo.sv
// ---------------------------------------------------------------------------
// ofifo : per-column psum FIFOs popped in lock-step by a single rd strobe.
// Optional sticky o_overflow with OFIFO_OVERFLOW_FLAG_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = OFIFO_COL,
  parameter int bw_psum = OFIFO_BW_PSUM,
  parameter int depth   = OFIFO_DEPTH
) (
  input wire logic clk,
  input wire logic reset,
  ofifo_if.slave   bus
);

  logic [col-1:0]         empty;
  logic [col-1:0]         full;
  logic [col*bw_psum-1:0] out_w;
  logic                   valid;
  logic                   pop;

  assign valid       = ~|empty;
  assign pop         = bus.rd & valid;
  assign bus.out     = out_w;
  assign bus.o_valid = valid;
  assign bus.o_full  = |full;
  assign bus.o_ready = ~(|full);

  generate
    for (genvar c = 0; c < col; c++) begin : g_col
      ofifo_col #(
        .bw_psum (bw_psum),
        .depth   (depth)
      ) u_col (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.wr[c]),
        .rd    (pop),
        .in    (bus.in[bw_psum*c +: bw_psum]),
        .out   (out_w[bw_psum*c +: bw_psum]),
        .empty (empty[c]),
        .full  (full[c])
      );
    end
  endgenerate

`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // A push into a full column is dropped unless the same edge pops it.
  always_comb begin
    overflow_d = overflow_q | ((|(bus.wr & full)) & ~pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign bus.o_overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ofifo.sv
// ---------------------------------------------------------------------------
// tb_ofifo : randomized and directed checks of ofifo against a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ofifo;
  import ofifo_pkg::*;

  localparam int COL   = OFIFO_COL;
  localparam int BW    = OFIFO_BW_PSUM;
  localparam int DEPTH = OFIFO_DEPTH;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [BW-1:0] q [COL][$];
  bit            ovf_m;

  ofifo_if #(.col(COL), .bw_psum(BW)) bus ();

  ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (q[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COL; c++) q[c].delete();
    ovf_m = 1'b0;
  endtask

  task automatic model_edge(input logic [COL-1:0] w, input logic r,
                            input logic [COL*BW-1:0] d);
    bit pop;
    bit full;
    bit acc;
    pop = r && m_valid();
    for (int c = 0; c < COL; c++) begin
      full = (q[c].size() == DEPTH);
      acc  = w[c] && (!full || pop);
      if (w[c] && !acc) ovf_m = 1'b1;
      if (pop) void'(q[c].pop_front());
      if (acc) q[c].push_back(d[c*BW +: BW]);
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", 32'(bus.o_valid), 32'(m_valid()));
    chk("o_full",  32'(bus.o_full),  32'(m_full()));
    chk("o_ready", 32'(bus.o_ready), 32'(!m_full()));
`ifdef OFIFO_OVERFLOW_FLAG_EN
    chk("o_overflow", 32'(bus.o_overflow), 32'(ovf_m));
`endif
    for (int c = 0; c < COL; c++)
      if (q[c].size() != 0)
        chk($sformatf("out_col%0d", c), 32'(bus.out[c*BW +: BW]), 32'(q[c][0]));
  endtask

  task automatic cycle(input logic [COL-1:0] w, input logic r, input logic [COL*BW-1:0] d);
    bus.wr = w;
    bus.rd = r;
    bus.in = d;
    @(posedge clk);
    model_edge(w, r, d);
    #1;
    check_outputs();
  endtask

  function automatic logic [COL*BW-1:0] rand_data();
    logic [COL*BW-1:0] d;
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'($urandom);
    return d;
  endfunction

  function automatic logic [COL*BW-1:0] fill_data(input int k);
    logic [COL*BW-1:0] d;
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'(c*16 + k);
    return d;
  endfunction

  // Hold reset across edges with traffic applied; nothing may be stored.
  task automatic apply_reset();
    reset  = 1'b0;
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rand_data();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset  = 1'b1;
    bus.wr = '0;
    bus.rd = 1'b0;
  endtask

  initial begin
    int pushed;
    int popped;
    bit w;
    bit r;
    logic [COL*BW-1:0] d;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.wr   = '0;
    bus.rd   = 1'b0;
    bus.in   = '0;
    model_clear();

    // Reset state and rd on an empty FIFO.
    apply_reset();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_full",  32'(bus.o_full),  32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    cycle('0, 1'b1, '0);
    chk("rd_empty_valid", 32'(bus.o_valid), 32'd0);

    // Staggered push: column 0 first, the rest two edges later.
    d = '0;
    d[BW-1:0] = BW'(24'h000011);
    cycle(8'h01, 1'b0, d);
    chk("stag_valid1", 32'(bus.o_valid), 32'd0);
    cycle('0, 1'b0, '0);
    chk("stag_valid2", 32'(bus.o_valid), 32'd0);
    cycle(8'hFE, 1'b0, rand_data());
    chk("stag_valid3", 32'(bus.o_valid), 32'd1);
    chk("stag_out0",   32'(bus.out[BW-1:0]), 32'h11);

    // Fill, overflow attempt, then drain in order.
    apply_reset();
    for (int k = 0; k < DEPTH; k++) cycle('1, 1'b0, fill_data(k));
    chk("fill_full",  32'(bus.o_full),  32'd1);
    chk("fill_ready", 32'(bus.o_ready), 32'd0);
    cycle('1, 1'b0, rand_data());
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_col3", 32'(bus.out[3*BW +: BW]), 32'(3*16 + k));
      cycle('0, 1'b1, '0);
    end
    chk("drain_valid", 32'(bus.o_valid), 32'd0);

    // Simultaneous push and pop while full.
    apply_reset();
    for (int k = 0; k < DEPTH; k++) cycle('1, 1'b0, fill_data(k));
    cycle('1, 1'b1, fill_data(8));
    chk("fullrw_full", 32'(bus.o_full), 32'd1);
    chk("fullrw_out7", 32'(bus.out[7*BW +: BW]), 32'(7*16 + 1));

    // Streaming across pointer wrap with occupancy held between 1 and 3.
    apply_reset();
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 400 && popped < 40; i++) begin
      r = m_valid() && ((q[0].size() > 1) || (pushed == 40)) && ($urandom_range(0, 1) == 1);
      w = (pushed < 40) && ((q[0].size() < 3) || r) && ($urandom_range(0, 3) != 0);
      if (r) popped++;
      if (w) pushed++;
      cycle({COL{w}}, r, rand_data());
    end
    chk("wrap_pops", 32'(popped), 32'd40);
    chk("wrap_empty", 32'(bus.o_valid), 32'd0);

    // Fully random per-column traffic, including drops on full columns.
    apply_reset();
    for (int i = 0; i < 300; i++)
      cycle(COL'($urandom), ($urandom_range(0, 2) == 0), rand_data());

    // Mid-operation reset with five entries stored (and a dropped push).
    apply_reset();
    for (int k = 0; k < DEPTH + 1; k++) cycle('1, 1'b0, fill_data(k));
    for (int k = 0; k < 3; k++) cycle('0, 1'b1, '0);
    chk("mid_valid_pre", 32'(bus.o_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_full",  32'(bus.o_full),  32'd0);
    chk("mid_ready", 32'(bus.o_ready), 32'd1);
`ifdef OFIFO_OVERFLOW_FLAG_EN
    chk("mid_ovf", 32'(bus.o_overflow), 32'd0);
`endif
    #1;
    reset = 1'b1;
    model_clear();
    cycle('1, 1'b0, fill_data(5));
    chk("post_rst_valid", 32'(bus.o_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 Parameter col, default 8, number of psum columns (one per MAC column).
REQ-002 Parameter bw_psum, default 22, width of one column's psum word.
REQ-003 Parameter depth, default 8, entries per column; SHALL be a power of two of at least 2.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; the same name as the codebase's reset port, with this block's fixed polarity.
REQ-006 in  input  col*bw_psum  psum from the MAC array; column c occupies bits [bw_psum*(c+1)-1 : bw_psum*c].
REQ-007 wr  input  col  per-column push strobes, driven from the MAC array's fifo_wr.
REQ-008 rd  input  1  pop request; pops one entry from every column at once.
REQ-009 out  output  col*bw_psum  head entry of each column, using the same column packing as in.
REQ-010 o_valid  output  1  high when every column holds at least one entry.
REQ-011 o_full  output  1  high when any column holds depth entries.
REQ-012 o_ready  output  1  equal to the inverse of o_full.

Function
REQ-013 Each column SHALL be an independent circular buffer with a write pointer and a read pointer, each (log2(depth)+1) bits wide, including a wrap bit.
- Column empty: the two pointers are equal.
- Column full: the low bits are equal and the wrap bits differ.
REQ-014 Push: wr[c]=1 at a clock edge SHALL store in column c's slice at the write pointer and increment that pointer, modulo 2*depth.
REQ-015 Pop: rd=1 while o_valid=1 SHALL increment every column's read pointer in that cycle.
REQ-016 rd=1 while o_valid=0 SHALL be ignored; no pointer moves.
REQ-017 out SHALL be first-word-fall-through: combinational read of each column's head entry.
- Data pushed into an empty column at edge N appears on out, and can contribute to o_valid, in the cycle after edge N.
REQ-018 A push to a full column SHALL be accepted only if that column is popped in the same cycle; otherwise the push SHALL be dropped and that column's storage left unchanged.
REQ-019 A simultaneous push and pop on a non-empty column SHALL leave its occupancy unchanged and advance both pointers.
REQ-020 A simultaneous push and pop on an empty column SHALL perform the push only, because o_valid=0 makes the pop a no-op.
REQ-021 Pointer wrap from 2*depth-1 to 0 SHALL be seamless, with no lost or duplicated entries.
REQ-022 o_valid, o_full and o_ready SHALL be combinational functions of the pointers only; they SHALL NOT depend on rd or wr in the same cycle.
REQ-023 Data SHALL pass through unmodified; the block performs no arithmetic on psum values.

Reset
REQ-024 While reset=0, asynchronously:
- all pointers SHALL be set to 0;
- o_valid=0, o_full=0, o_ready=1;
- out SHALL be don't-care, because storage is not reset.
REQ-025 Assertion of reset in the middle of an operation SHALL discard all stored entries immediately; no pop or push SHALL complete on the edge where reset is low.
REQ-026 After reset deasserts, the first rising edge SHALL accept pushes normally.

Configuration
REQ-027 Macro OFIFO_OVERFLOW_FLAG_EN.
- When defined, the block SHALL add output port o_overflow (1 bit). It is sticky and set on any push dropped under REQ-018. It is cleared only by reset.
- When undefined, the port and its logic SHALL be absent, and dropped pushes SHALL be silent.

Structure
REQ-028 Package ofifo_pkg SHALL hold constants OFIFO_COL, OFIFO_BW_PSUM, OFIFO_DEPTH and OFIFO_PTR_W (= log2(depth)+1), used as the parameter defaults.
REQ-029 A sub-module ofifo_col SHALL implement one column's buffer.
- Ports: clk, reset, wr, rd, in, out, empty, full.
- ofifo SHALL instantiate col copies of it and combine their empty and full flags into o_valid and o_full.

Verification
REQ-030 Reset: hold reset=0, then release. Required: o_valid=0, o_full=0, o_ready=1; rd=1 has no effect.
REQ-031 Staggered push: push 0x000011 to column 0 at edge 1, then to columns 1..7 at edge 3.
- o_valid SHALL stay 0 until the cycle after edge 3, then read 1.
- out column 0 SHALL equal 0x000011.
REQ-032 Fill: push depth=8 words per column (values c*16+k) with no reads.
- o_full=1 and o_ready=0 after the eighth push.
- A ninth push is dropped.
- Eight pops SHALL return k=0..7 in order; then o_valid=0.
REQ-033 Full with simultaneous traffic: on full columns, wr=all-ones and rd=1 in the same cycle.
- The push is accepted and the oldest entry is popped.
- o_full stays 1.
- The next out equals the second-oldest entries.
REQ-034 Wrap: stream 40 pushes and 40 pops on all columns, with occupancy kept between 1 and 3 (rd asserted only while o_valid=1). Required: every value is returned exactly once, in order, across pointer wrap.
REQ-035 Mid-operation reset: with 5 entries stored, pulse reset=0 between clock edges.
- o_valid SHALL fall immediately.
- With OFIFO_OVERFLOW_FLAG_EN defined, a previously set o_overflow SHALL clear.
